// File: rtl/match_controller.sv
// Pattern-match capture controller: loads NUM_PAT comparator patterns, streams FIFO words past them,
// and writes each hit (word + lowest matching channel) into a capture memory. rdreq to mem_we is 4 cycles.
module match_controller #(
    parameter int DATA_W    = 32,
    parameter int NUM_PAT   = 4,
    parameter int ADDR_W    = 8,
    parameter int WRAP_MODE = 0,
    localparam int IDX_W    = $clog2(NUM_PAT)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                cfg_valid,
    input  logic [DATA_W-1:0]   cfg_data,
    input  logic                cfg_reload,
    input  logic                clear_err,
    input  logic                fifo_empty,
    input  logic [DATA_W-1:0]   fifo_rdata,
    output logic                rdreq,
    output logic [NUM_PAT-1:0]  comp_load,
    output logic [DATA_W-1:0]   comp_data,
    output logic                comp_valid,
    input  logic [NUM_PAT-1:0]  match_vec,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [IDX_W-1:0]    mem_tag,
    output logic [15:0]         match_count,
    output logic                mem_full,
    output logic                error
);

    typedef enum logic [2:0] {
        S_RESET, S_LOAD_COMP_REG, S_IDLE, S_READ_FIFO,
        S_COMPARE, S_MATCH_FOUND, S_LOAD_MEMORY, S_ERROR
    } state_t;

    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_PAT - 1);
    localparam logic [NUM_PAT-1:0] ONE_HOT0 = NUM_PAT'(1);

    state_t              r_state, w_next;
    logic [IDX_W-1:0]    r_idx;
    logic [DATA_W-1:0]   r_word;
    logic [IDX_W-1:0]    r_tag;
    logic [IDX_W-1:0]    w_hit_idx;
    logic                w_hit;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [IDX_W-1:0]    r_mem_tag;
    logic                r_full;
    logic [15:0]         r_count;

    // Scan from the top so the lowest set channel is the last one written.
    always_comb begin
        w_hit_idx = '0;
        for (int i = NUM_PAT - 1; i >= 0; i--) begin
            if (match_vec[i]) w_hit_idx = IDX_W'(i);
        end
    end

    assign w_hit = |match_vec;

    always_comb begin
        w_next     = r_state;
        rdreq      = 1'b0;
        comp_load  = '0;
        comp_data  = '0;
        comp_valid = 1'b0;
        case (r_state)
            S_RESET:         w_next = S_LOAD_COMP_REG;
            S_LOAD_COMP_REG: begin
                if (cfg_valid) begin
                    comp_load = ONE_HOT0 << r_idx;
                    comp_data = cfg_data;
                    if (r_idx == LAST_IDX) w_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (cfg_reload) begin
                    w_next = S_LOAD_COMP_REG;
                end else if (!fifo_empty) begin
                    rdreq  = 1'b1;
                    w_next = S_READ_FIFO;
                end
            end
            S_READ_FIFO:     w_next = S_COMPARE;
            S_COMPARE: begin
                comp_valid = 1'b1;
                comp_data  = r_word;
                w_next     = w_hit ? S_MATCH_FOUND : S_IDLE;
            end
            S_MATCH_FOUND:   w_next = (r_full && (WRAP_MODE == 0)) ? S_ERROR : S_LOAD_MEMORY;
            S_LOAD_MEMORY:   w_next = S_IDLE;
            S_ERROR:         if (clear_err) w_next = S_IDLE;
            default:         w_next = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= S_RESET;
            r_idx       <= '0;
            r_word      <= '0;
            r_tag       <= '0;
            r_ptr       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_tag   <= '0;
            r_full      <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_LOAD_COMP_REG: if (cfg_valid) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
                S_IDLE:          if (cfg_reload) r_idx <= '0;
                S_READ_FIFO:     r_word <= fifo_rdata;
                S_COMPARE:       r_tag <= w_hit_idx;
                S_MATCH_FOUND: begin
                    // Memory-port registers only move on a real write so they hold otherwise.
                    if (w_next == S_LOAD_MEMORY) begin
                        r_mem_addr  <= r_ptr;
                        r_mem_wdata <= r_word;
                        r_mem_tag   <= r_tag;
                    end
                end
                S_LOAD_MEMORY: begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                    if ((WRAP_MODE == 0) && (r_ptr == '1)) r_full <= 1'b1;
                    if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
                end
                S_ERROR: begin
                    if (clear_err) begin
                        r_ptr   <= '0;
                        r_full  <= 1'b0;
                        r_count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we      = (r_state == S_LOAD_MEMORY);
    assign error       = (r_state == S_ERROR);
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_tag     = r_mem_tag;
    assign match_count = r_count;
    assign mem_full    = r_full;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: instance 0 stops on full (ADDR_W=2), instance 1 wraps (ADDR_W=2).
// Capture behaviour is predicted from a count of captures since reset/clear.
module tb_match_controller;
    localparam int DW = 32;
    localparam int NP = 4;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic n_rst;
    logic            cfg_valid  [2];
    logic [DW-1:0]   cfg_data   [2];
    logic            cfg_reload [2];
    logic            clear_err  [2];
    logic            fifo_empty [2];
    logic [DW-1:0]   fifo_rdata [2];
    logic [NP-1:0]   match_vec  [2];
    logic            rdreq      [2];
    logic [NP-1:0]   comp_load  [2];
    logic [DW-1:0]   comp_data  [2];
    logic            comp_valid [2];
    logic            mem_we     [2];
    logic [AW-1:0]   mem_addr   [2];
    logic [DW-1:0]   mem_wdata  [2];
    logic [1:0]      mem_tag    [2];
    logic [15:0]     match_count[2];
    logic            mem_full   [2];
    logic            error      [2];

    int n_tests = 0;
    int n_fail  = 0;
    int m_n   [2];
    bit m_err [2];

    always #5 clk = ~clk;

    match_controller #(.DATA_W(DW), .NUM_PAT(NP), .ADDR_W(AW), .WRAP_MODE(0)) u_stop (
        .clk(clk), .n_rst(n_rst), .cfg_valid(cfg_valid[0]), .cfg_data(cfg_data[0]),
        .cfg_reload(cfg_reload[0]), .clear_err(clear_err[0]), .fifo_empty(fifo_empty[0]),
        .fifo_rdata(fifo_rdata[0]), .rdreq(rdreq[0]), .comp_load(comp_load[0]),
        .comp_data(comp_data[0]), .comp_valid(comp_valid[0]), .match_vec(match_vec[0]),
        .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_tag(mem_tag[0]), .match_count(match_count[0]), .mem_full(mem_full[0]),
        .error(error[0])
    );

    match_controller #(.DATA_W(DW), .NUM_PAT(NP), .ADDR_W(AW), .WRAP_MODE(1)) u_wrap (
        .clk(clk), .n_rst(n_rst), .cfg_valid(cfg_valid[1]), .cfg_data(cfg_data[1]),
        .cfg_reload(cfg_reload[1]), .clear_err(clear_err[1]), .fifo_empty(fifo_empty[1]),
        .fifo_rdata(fifo_rdata[1]), .rdreq(rdreq[1]), .comp_load(comp_load[1]),
        .comp_data(comp_data[1]), .comp_valid(comp_valid[1]), .match_vec(match_vec[1]),
        .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_tag(mem_tag[1]), .match_count(match_count[1]), .mem_full(mem_full[1]),
        .error(error[1])
    );

    task automatic chk(input int k, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    function automatic logic [31:0] lowest(input logic [3:0] mv);
        for (int i = 0; i < NP; i++) begin
            if (mv[i]) return 32'(i);
        end
        return 32'd0;
    endfunction

    function automatic logic [31:0] exp_count(input int n);
        return (n > 65535) ? 32'd65535 : 32'(n);
    endfunction

    task automatic zero_chk(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk(k, {tag, "_rdreq"},  rdreq[k], 0);
            chk(k, {tag, "_cload"},  comp_load[k], 0);
            chk(k, {tag, "_cdata"},  comp_data[k], 0);
            chk(k, {tag, "_cvalid"}, comp_valid[k], 0);
            chk(k, {tag, "_we"},     mem_we[k], 0);
            chk(k, {tag, "_addr"},   mem_addr[k], 0);
            chk(k, {tag, "_wdata"},  mem_wdata[k], 0);
            chk(k, {tag, "_tag"},    mem_tag[k], 0);
            chk(k, {tag, "_count"},  match_count[k], 0);
            chk(k, {tag, "_full"},   mem_full[k], 0);
            chk(k, {tag, "_error"},  error[k], 0);
        end
    endtask

    // Entered mid-cycle; drops reset immediately, then releases it at the next falling edge.
    task automatic do_reset();
        n_rst = 1'b0;
        #1;
        zero_chk("async_rst");
        for (int k = 0; k < 2; k++) begin
            m_n[k]   = 0;
            m_err[k] = 1'b0;
        end
        nxt();
        n_rst = 1'b1;
        fifo_empty[0] = 1'b0;
        fifo_empty[1] = 1'b0;
        #1;
        zero_chk("reset_state");
        fifo_empty[0] = 1'b1;
        fifo_empty[1] = 1'b1;
    endtask

    task automatic load_pats(input int k);
        int gaps;
        logic [31:0] d;
        for (int i = 0; i < NP; i++) begin
            gaps = (i == 1) ? 1 : int'($urandom_range(0, 2));
            repeat (gaps) begin
                nxt();
                cfg_valid[k] = 1'b0; cfg_reload[k] = 1'b0; fifo_empty[k] = 1'b0;
                cfg_data[k] = $urandom;
                #1;
                chk(k, "load_gap", comp_load[k], 0);
                chk(k, "load_rdreq", rdreq[k], 0);
            end
            nxt();
            d = $urandom;
            cfg_valid[k] = 1'b1; cfg_data[k] = d; cfg_reload[k] = 1'b0; fifo_empty[k] = 1'b0;
            #1;
            chk(k, "load_onehot", comp_load[k], 32'd1 << i);
            chk(k, "load_data", comp_data[k], d);
            chk(k, "load_rdreq", rdreq[k], 0);
        end
        nxt();
        cfg_valid[k] = 1'b1; cfg_data[k] = $urandom; fifo_empty[k] = 1'b1;
        #1;
        chk(k, "idle_cload", comp_load[k], 0);
        chk(k, "idle_cdata", comp_data[k], 0);
        cfg_valid[k] = 1'b0;
    endtask

    // One FIFO word through IDLE..LOAD_MEMORY; with rst_lm the caller resets during the write cycle.
    task automatic txn(input int k, input logic [31:0] w, input logic [3:0] mv, input bit rst_lm);
        nxt();
        fifo_empty[k] = 1'b0; fifo_rdata[k] = w; match_vec[k] = mv;
        #1;
        chk(k, "rdreq_idle", rdreq[k], 1);
        nxt();
        fifo_empty[k] = 1'b1;
        #1;
        chk(k, "rdreq_read", rdreq[k], 0);
        chk(k, "we_read", mem_we[k], 0);
        nxt();
        fifo_rdata[k] = $urandom;
        #1;
        chk(k, "cmp_valid", comp_valid[k], 1);
        chk(k, "cmp_data", comp_data[k], w);
        chk(k, "cmp_rdreq", rdreq[k], 0);
        nxt();
        #1;
        if (mv == 4'b0000) begin
            chk(k, "nomatch_we", mem_we[k], 0);
            chk(k, "nomatch_cvalid", comp_valid[k], 0);
            chk(k, "nomatch_cdata", comp_data[k], 0);
            chk(k, "nomatch_count", match_count[k], exp_count(m_n[k]));
            return;
        end
        chk(k, "found_we", mem_we[k], 0);
        nxt();
        #1;
        if (k == 0 && m_n[k] >= DEPTH) begin
            chk(k, "full_error", error[k], 1);
            chk(k, "full_we", mem_we[k], 0);
            m_err[k] = 1'b1;
            return;
        end
        chk(k, "wr_we", mem_we[k], 1);
        chk(k, "wr_addr", mem_addr[k], m_n[k] % DEPTH);
        chk(k, "wr_wdata", mem_wdata[k], w);
        chk(k, "wr_tag", mem_tag[k], lowest(mv));
        chk(k, "wr_error", error[k], 0);
        if (rst_lm) return;
        m_n[k]++;
        nxt();
        #1;
        chk(k, "post_we", mem_we[k], 0);
        chk(k, "post_count", match_count[k], exp_count(m_n[k]));
        chk(k, "post_full", mem_full[k], (k == 0 && m_n[k] >= DEPTH) ? 1 : 0);
        chk(k, "hold_addr", mem_addr[k], (m_n[k] - 1) % DEPTH);
        chk(k, "hold_wdata", mem_wdata[k], w);
    endtask

    task automatic do_clear(input int k);
        nxt();
        fifo_empty[k] = 1'b0;
        #1;
        chk(k, "err_hold", error[k], 1);
        chk(k, "err_rdreq", rdreq[k], 0);
        chk(k, "err_we", mem_we[k], 0);
        chk(k, "err_cdata", comp_data[k], 0);
        nxt();
        fifo_empty[k] = 1'b1; clear_err[k] = 1'b1;
        #1;
        chk(k, "err_still", error[k], 1);
        nxt();
        clear_err[k] = 1'b0;
        #1;
        m_n[k]   = 0;
        m_err[k] = 1'b0;
        chk(k, "clr_error", error[k], 0);
        chk(k, "clr_count", match_count[k], 0);
        chk(k, "clr_full", mem_full[k], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cfg_valid[k] = 1'b0; cfg_data[k] = '0; cfg_reload[k] = 1'b0; clear_err[k] = 1'b0;
            fifo_empty[k] = 1'b1; fifo_rdata[k] = '0; match_vec[k] = '0;
        end
        @(negedge clk);
        do_reset();
        load_pats(0);
        load_pats(1);

        // Stop-on-full instance: directed captures, then overflow into ERROR.
        txn(0, 32'hDEADBEEF, 4'b0100, 1'b0);
        txn(0, $urandom, 4'b0110, 1'b0);
        txn(0, $urandom, 4'b0000, 1'b0);
        txn(0, $urandom, 4'b1000, 1'b0);
        txn(0, $urandom, 4'b1111, 1'b0);
        txn(0, $urandom, 4'b0001, 1'b0);
        if (m_err[0]) do_clear(0);
        txn(0, $urandom, 4'b0010, 1'b0);

        // Reload wins over pending FIFO data.
        nxt();
        cfg_reload[0] = 1'b1; fifo_empty[0] = 1'b0;
        #1;
        chk(0, "reload_prio_rdreq", rdreq[0], 0);
        load_pats(0);
        txn(0, $urandom, 4'b1010, 1'b0);

        for (int j = 0; j < 40; j++) begin
            if (m_err[0]) do_clear(0);
            else txn(0, $urandom, 4'($urandom_range(0, 15)), 1'b0);
        end

        // Wrapping instance: five captures wrap to address 0 without error.
        for (int j = 0; j < 5; j++) txn(1, $urandom, 4'($urandom_range(1, 15)), 1'b0);
        for (int j = 0; j < 30; j++) txn(1, $urandom, 4'($urandom_range(0, 15)), 1'b0);

        // Reset asserted in the middle of a memory write cycle.
        txn(1, $urandom, 4'b0010, 1'b1);
        do_reset();
        load_pats(0);
        load_pats(1);
        txn(1, $urandom, 4'b0100, 1'b0);
        txn(0, $urandom, 4'b1000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
